// File: rtl/sub_sink_bfs_if.sv
// Bundle of the search request, board read port and result signals.
// Latency: none, pure wiring.
// Backpressure: board reads are held by the searcher until mem_data_out_valid.
interface sub_sink_bfs_if #(
    parameter int GRID_BITS = 3
);
    logic                 bfs_start;
    logic [GRID_BITS-1:0] start_x;
    logic [GRID_BITS-1:0] start_y;
    logic [GRID_BITS-1:0] mem_x;
    logic [GRID_BITS-1:0] mem_y;
    logic                 mem_rd;
    logic [1:0]           mem_data_out;
    logic                 mem_data_out_valid;
    logic                 bfs_sink;
    logic                 bfs_done;
    logic                 busy;

    // Searcher side.
    modport slave (
        input  bfs_start, start_x, start_y, mem_data_out, mem_data_out_valid,
        output mem_x, mem_y, mem_rd, bfs_sink, bfs_done, busy
    );

    // Requester / board side.
    modport master (
        output bfs_start, start_x, start_y, mem_data_out, mem_data_out_valid,
        input  mem_x, mem_y, mem_rd, bfs_sink, bfs_done, busy
    );
endinterface

// File: rtl/sub_sink_bfs.sv
// Breadth-first flood over hit ship cells from a just-hit cell; reports whether the whole sub is sunk.
// Latency: one cycle per neighbour probe plus board read wait; bfs_done pulses one cycle in FINISH.
// Backpressure: a board read is held (mem_rd, mem_x, mem_y stable) until mem_data_out_valid; bfs_start only taken in IDLE.
module sub_sink_bfs #(
    parameter int GRID_BITS = 3
) (
    input  logic           clk,
    input  logic           rst,
    sub_sink_bfs_if.slave  bus
);
    localparam int AW    = 2 * GRID_BITS;
    localparam int CW    = AW + 1;
    localparam int CELLS = 1 << AW;
    localparam logic [GRID_BITS-1:0] GMAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        NEXT_NBR,
        READ,
        FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [CELLS-1:0]     visited_q, visited_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [GRID_BITS-1:0] cur_x_q, cur_x_d;
    logic [GRID_BITS-1:0] cur_y_q, cur_y_d;
    logic [GRID_BITS-1:0] nbr_x_q, nbr_x_d;
    logic [GRID_BITS-1:0] nbr_y_q, nbr_y_d;
    logic [2:0]           nbr_idx_q, nbr_idx_d;
    logic                 sink_q, sink_d;

    // Queue storage: every cell is enqueued at most once per search, so CELLS entries never overflow.
    logic [AW-1:0]        fifo_mem [CELLS];
    logic                 push_vld;
    logic [AW-1:0]        push_ptr;
    logic [AW-1:0]        push_dat;

    logic [GRID_BITS-1:0] cand_x;
    logic [GRID_BITS-1:0] cand_y;
    logic                 cand_ok;
    logic                 cand_free;

    // Candidate neighbour for the current index: up, down, left, right; edges never wrap.
    always_comb begin
        cand_x  = cur_x_q;
        cand_y  = cur_y_q;
        cand_ok = 1'b0;
        case (nbr_idx_q)
            3'd0: begin
                cand_y  = cur_y_q - GRID_BITS'(1);
                cand_ok = (cur_y_q != '0);
            end
            3'd1: begin
                cand_y  = cur_y_q + GRID_BITS'(1);
                cand_ok = (cur_y_q != GMAX);
            end
            3'd2: begin
                cand_x  = cur_x_q - GRID_BITS'(1);
                cand_ok = (cur_x_q != '0);
            end
            3'd3: begin
                cand_x  = cur_x_q + GRID_BITS'(1);
                cand_ok = (cur_x_q != GMAX);
            end
            default: cand_ok = 1'b0;
        endcase
        cand_free = cand_ok && !visited_q[{cand_y, cand_x}];
    end

    // Next-state and datapath update for the search walk.
    always_comb begin
        state_d   = state_q;
        visited_d = visited_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        nbr_x_d   = nbr_x_q;
        nbr_y_d   = nbr_y_q;
        nbr_idx_d = nbr_idx_q;
        sink_d    = sink_q;
        push_vld  = 1'b0;
        push_ptr  = wr_ptr_q;
        push_dat  = {nbr_y_q, nbr_x_q};

        case (state_q)
            IDLE: begin
                if (bus.bfs_start) begin
                    // Start cell is taken as hit without reading it; map and queue restart empty.
                    visited_d                            = '0;
                    visited_d[{bus.start_y, bus.start_x}] = 1'b1;
                    push_vld  = 1'b1;
                    push_ptr  = '0;
                    push_dat  = {bus.start_y, bus.start_x};
                    rd_ptr_d  = '0;
                    wr_ptr_d  = AW'(1);
                    cnt_d     = CW'(1);
                    sink_d    = 1'b0;
                    state_d   = POP;
                end
            end
            POP: begin
                if (cnt_q == '0) begin
                    sink_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    {cur_y_d, cur_x_d} = fifo_mem[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + AW'(1);
                    cnt_d     = cnt_q - CW'(1);
                    nbr_idx_d = 3'd0;
                    state_d   = NEXT_NBR;
                end
            end
            NEXT_NBR: begin
                if (nbr_idx_q == 3'd4) begin
                    state_d = POP;
                end else if (cand_free) begin
                    nbr_x_d = cand_x;
                    nbr_y_d = cand_y;
                    state_d = READ;
                end else begin
                    nbr_idx_d = nbr_idx_q + 3'd1;
                end
            end
            READ: begin
                if (bus.mem_data_out_valid) begin
                    if (bus.mem_data_out == 2'b01) begin
                        // An intact ship cell means the sub is still afloat; stop right away.
                        sink_d  = 1'b0;
                        state_d = FINISH;
                    end else begin
                        visited_d[{nbr_y_q, nbr_x_q}] = 1'b1;
                        if (bus.mem_data_out == 2'b10) begin
                            push_vld = 1'b1;
                            wr_ptr_d = wr_ptr_q + AW'(1);
                            cnt_d    = cnt_q + CW'(1);
                        end
                        nbr_idx_d = nbr_idx_q + 3'd1;
                        state_d   = NEXT_NBR;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            visited_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            nbr_x_q   <= '0;
            nbr_y_q   <= '0;
            nbr_idx_q <= '0;
            sink_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            visited_q <= visited_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            nbr_x_q   <= nbr_x_d;
            nbr_y_q   <= nbr_y_d;
            nbr_idx_q <= nbr_idx_d;
            sink_q    <= sink_d;
        end
    end

    // Queue write port; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && push_vld) begin
            fifo_mem[push_ptr] <= push_dat;
        end
    end

    // Outputs decoded from state; the address is forced to zero outside READ.
    always_comb begin
        bus.mem_rd   = (state_q == READ);
        bus.mem_x    = (state_q == READ) ? nbr_x_q : '0;
        bus.mem_y    = (state_q == READ) ? nbr_y_q : '0;
        bus.busy     = (state_q == POP) || (state_q == NEXT_NBR) || (state_q == READ);
        bus.bfs_done = (state_q == FINISH);
        bus.bfs_sink = sink_q;
    end
endmodule

// File: tb/tb_sub_sink_bfs.sv
// Scoreboard bench for sub_sink_bfs: board model answers reads, monitor checks read order and results.
// Latency: configurable board read delay per test.
// Backpressure: read valid withheld for rd_delay cycles to exercise address hold.
module tb_sub_sink_bfs;
    localparam int GB = 3;

    logic clk;
    logic rst;

    sub_sink_bfs_if #(.GRID_BITS(GB)) bus ();

    sub_sink_bfs #(.GRID_BITS(GB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_chk = 0;
    int         n_err = 0;
    logic [1:0] board [64];
    int         rd_delay = 0;
    logic [5:0] exp_rd_q [$];
    bit         exp_sink_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] xy(input int x, input int y);
        return 6'(y * 8 + x);
    endfunction

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = 2'b00;
    endtask

    task automatic set_cell(input int x, input int y, input logic [1:0] v);
        board[xy(x, y)] = v;
    endtask

    task automatic exp_read(input int x, input int y);
        exp_rd_q.push_back(xy(x, y));
    endtask

    // Board model and monitor: answers reads, checks address order/hold and each completion.
    initial begin
        int         wait_cnt;
        logic [5:0] first_addr;
        logic [5:0] a;
        logic [5:0] ea;
        bit         moved;
        bit         prev_ship;
        bit         e;
        wait_cnt   = 0;
        first_addr = '0;
        moved      = 1'b0;
        prev_ship  = 1'b0;
        bus.mem_data_out_valid = 1'b0;
        bus.mem_data_out       = 2'b00;
        forever begin
            @(negedge clk);
            if (prev_ship) check("early_exit_timing", int'(bus.bfs_done), 1);
            prev_ship = 1'b0;
            if (bus.bfs_done) begin
                if (exp_sink_q.size() == 0) begin
                    check("unexpected_done", int'(bus.bfs_done), 0);
                end else begin
                    e = exp_sink_q.pop_front();
                    check("bfs_sink", int'(bus.bfs_sink), int'(e));
                    check("busy_at_done", int'(bus.busy), 0);
                    check("reads_pending", exp_rd_q.size(), 0);
                    exp_rd_q.delete();
                end
            end
            if (bus.mem_rd) begin
                a = {bus.mem_y, bus.mem_x};
                if (wait_cnt == 0) first_addr = a;
                else if (a != first_addr) moved = 1'b1;
                if (wait_cnt >= rd_delay) begin
                    bus.mem_data_out_valid = 1'b1;
                    bus.mem_data_out       = board[a];
                    if (board[a] == 2'b01) prev_ship = 1'b1;
                    check("addr_stable", int'(moved), 0);
                    if (exp_rd_q.size() == 0) begin
                        check("unexpected_read", int'(bus.mem_rd), 0);
                    end else begin
                        ea = exp_rd_q.pop_front();
                        check("read_addr", int'(a), int'(ea));
                    end
                end else begin
                    bus.mem_data_out_valid = 1'b0;
                end
                wait_cnt++;
            end else begin
                bus.mem_data_out_valid = 1'b0;
                wait_cnt = 0;
                moved    = 1'b0;
            end
        end
    end

    task automatic start_search(input int sx, input int sy);
        @(negedge clk);
        bus.start_x   = 3'(sx);
        bus.start_y   = 3'(sy);
        bus.bfs_start = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_start", int'(bus.busy), 1);
        check("sink_cleared", int'(bus.bfs_sink), 0);
        @(negedge clk);
        bus.bfs_start = 1'b0;
    endtask

    task automatic run(input int sx, input int sy, input bit es, input bit poke_finish);
        bit seen;
        seen = 1'b0;
        exp_sink_q.push_back(es);
        start_search(sx, sy);
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (bus.bfs_done) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) check("done_timeout", int'(bus.bfs_done), 1);
        if (poke_finish && seen) begin
            bus.bfs_start = 1'b1;
            @(negedge clk);
            bus.bfs_start = 1'b0;
            check("start_in_finish_ignored", int'(bus.busy), 0);
        end
        repeat (3) @(negedge clk);
        check("sink_hold", int'(bus.bfs_sink), int'(es));
        check("idle_busy", int'(bus.busy), 0);
    endtask

    task automatic ship_row(input logic [1:0] right_code);
        clear_board();
        set_cell(1, 3, 2'b10);
        set_cell(2, 3, 2'b10);
        set_cell(3, 3, right_code);
    endtask

    initial begin
        bit got_rd;
        rst           = 1'b1;
        bus.bfs_start = 1'b0;
        bus.start_x   = '0;
        bus.start_y   = '0;
        clear_board();
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.bfs_done), 0);
        check("rst_sink", int'(bus.bfs_sink), 0);
        check("rst_mem_rd", int'(bus.mem_rd), 0);
        check("rst_mem_x", int'(bus.mem_x), 0);
        check("rst_mem_y", int'(bus.mem_y), 0);
        rst = 1'b0;

        // Single-cell sub at (2,2), zero-latency board.
        clear_board();
        set_cell(2, 2, 2'b10);
        rd_delay = 0;
        exp_read(2, 1); exp_read(2, 3); exp_read(1, 2); exp_read(3, 2);
        run(2, 2, 1'b1, 1'b0);

        // Three-cell horizontal sub, fully hit.
        ship_row(2'b10);
        exp_read(2, 2); exp_read(2, 4); exp_read(1, 3); exp_read(3, 3);
        exp_read(1, 2); exp_read(1, 4); exp_read(0, 3);
        exp_read(3, 2); exp_read(3, 4); exp_read(4, 3);
        run(2, 3, 1'b1, 1'b0);

        // Same sub with an intact end: early exit after the fourth read.
        ship_row(2'b01);
        exp_read(2, 2); exp_read(2, 4); exp_read(1, 3); exp_read(3, 3);
        run(2, 3, 1'b0, 1'b0);

        // Corner start; a start raised during FINISH must be ignored.
        clear_board();
        set_cell(0, 0, 2'b10);
        exp_read(0, 1); exp_read(1, 0);
        run(0, 0, 1'b1, 1'b1);

        // Slow board: valid three cycles after each read request.
        clear_board();
        set_cell(2, 2, 2'b10);
        set_cell(2, 1, 2'b11);
        rd_delay = 3;
        exp_read(2, 1); exp_read(2, 3); exp_read(1, 2); exp_read(3, 2);
        run(2, 2, 1'b1, 1'b0);

        // Abort during READ; reset also beats a simultaneous start.
        ship_row(2'b10);
        rd_delay = 255;
        start_search(2, 3);
        got_rd = 1'b0;
        for (int i = 0; i < 50 && !got_rd; i++) begin
            if (bus.mem_rd) got_rd = 1'b1;
            else @(negedge clk);
        end
        check("abort_reached_read", int'(bus.mem_rd), 1);
        repeat (2) @(negedge clk);
        rst           = 1'b1;
        bus.bfs_start = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_mem_rd", int'(bus.mem_rd), 0);
        check("abort_done", int'(bus.bfs_done), 0);
        check("abort_mem_x", int'(bus.mem_x), 0);
        @(negedge clk);
        rst           = 1'b0;
        bus.bfs_start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_beats_start", int'(bus.busy), 0);

        // Fresh search after the abort.
        clear_board();
        set_cell(2, 2, 2'b10);
        rd_delay = 0;
        exp_read(2, 1); exp_read(2, 3); exp_read(1, 2); exp_read(3, 2);
        run(2, 2, 1'b1, 1'b0);

        repeat (5) @(negedge clk);
        check("leftover_expected_done", exp_sink_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
